// File: rtl/mem_arb_pkg.sv
// Shared definitions for the data-memory arbiter and its helpers.
//   arb_state_e : arbiter FSM state encoding
//   StatsWidth  : width of each per-core grant counter (MEM_ARB_STATS_EN builds)
package mem_arb_pkg;

   typedef enum logic [1:0] {
      StIdle   = 2'd0,
      StAccess = 2'd1,
      StWait   = 2'd2,
      StResp   = 2'd3
   } arb_state_e;

   localparam int unsigned StatsWidth = 16;

endpackage

// File: rtl/rr_select.sv
// Combinational rotating-priority pick.
// Ports:
//   req    : per-requester request vector
//   last   : index of the most recently served requester
//   valid  : at least one request present
//   winner : first set req bit searching last+1, last+2, ... modulo CORE_COUNT
module rr_select
   import mem_arb_pkg::*;
#(
   parameter  int unsigned CORE_COUNT = 2,
   localparam int unsigned IdxWidth   = $clog2(CORE_COUNT)
) (
   input  logic [CORE_COUNT-1:0] req,
   input  logic [IdxWidth-1:0]   last,
   output logic                  valid,
   output logic [IdxWidth-1:0]   winner
);

   int idx;

   always_comb begin
      valid  = 1'b0;
      winner = '0;
      idx    = 0;
      // Scan from the farthest candidate to the nearest so the nearest set bit wins.
      for (int k = int'(CORE_COUNT); k >= 1; k--) begin
         idx = (int'(last) + k) % int'(CORE_COUNT);
         if (req[idx]) begin
            valid  = 1'b1;
            winner = IdxWidth'(idx);
         end
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port data memory among CORE_COUNT cores.
// One transaction at a time: select (IDLE), strobe (ACCESS), wait MEM_LATENCY, respond.
// Optional macro MEM_ARB_STATS_EN adds grant_cnt, one saturating 16-bit counter per core.
// Ports:
//   clk, rstN               : clock, asynchronous active-low reset
//   req/wrEn/addr/wrData    : per-core request ports, core i in slice i
//   done                    : one-hot completion pulse
//   rdData                  : read data broadcast, valid with done, held until next read
//   busy                    : arbiter not idle
//   mem_addr/mem_wrData     : shared memory address / write data, held outside ACCESS
//   mem_wrEn/mem_rdEn       : memory strobes, high for the single ACCESS cycle
//   mem_rdData              : memory read data, valid MEM_LATENCY cycles after strobe
//   grant_cnt               : (MEM_ARB_STATS_EN only) per-core grant counters
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned CORE_COUNT  = 2,
   parameter int unsigned ADDR_WIDTH  = 12,
   parameter int unsigned DATA_WIDTH  = 12,
   parameter int unsigned MEM_LATENCY = 1
) (
   input  logic                             clk,
   input  logic                             rstN,
   input  logic [CORE_COUNT-1:0]            req,
   input  logic [CORE_COUNT-1:0]            wrEn,
   input  logic [CORE_COUNT*ADDR_WIDTH-1:0] addr,
   input  logic [CORE_COUNT*DATA_WIDTH-1:0] wrData,
   output logic [CORE_COUNT-1:0]            done,
   output logic [DATA_WIDTH-1:0]            rdData,
   output logic                             busy,
   output logic [ADDR_WIDTH-1:0]            mem_addr,
   output logic [DATA_WIDTH-1:0]            mem_wrData,
   output logic                             mem_wrEn,
   output logic                             mem_rdEn,
   input  logic [DATA_WIDTH-1:0]            mem_rdData
`ifdef MEM_ARB_STATS_EN
   ,
   output logic [CORE_COUNT*StatsWidth-1:0] grant_cnt
`endif
);

   localparam int unsigned IdxWidth = $clog2(CORE_COUNT);
   localparam int unsigned CntWidth = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

   arb_state_e            state_q, state_d;
   logic [IdxWidth-1:0]   last_q, last_d;
   logic [IdxWidth-1:0]   win_q, win_d;
   logic                  wren_q, wren_d;
   logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_WIDTH-1:0] mem_wrdata_q, mem_wrdata_d;
   logic [DATA_WIDTH-1:0] rddata_q, rddata_d;
   logic [CntWidth-1:0]   cnt_q, cnt_d;

   logic                  sel_valid;
   logic [IdxWidth-1:0]   sel_idx;

   rr_select #(
      .CORE_COUNT (CORE_COUNT)
   ) u_rr_select (
      .req    (req),
      .last   (last_q),
      .valid  (sel_valid),
      .winner (sel_idx)
   );

   always_comb begin
      state_d      = state_q;
      last_d       = last_q;
      win_d        = win_q;
      wren_d       = wren_q;
      mem_addr_d   = mem_addr_q;
      mem_wrdata_d = mem_wrdata_q;
      rddata_d     = rddata_q;
      cnt_d        = cnt_q;
      case (state_q)
         StIdle: begin
            // The winner's request is latched straight into the memory-side registers,
            // so they change only on entry to ACCESS and hold afterwards.
            if (sel_valid) begin
               win_d        = sel_idx;
               wren_d       = wrEn[sel_idx];
               mem_addr_d   = addr[sel_idx*ADDR_WIDTH +: ADDR_WIDTH];
               mem_wrdata_d = wrData[sel_idx*DATA_WIDTH +: DATA_WIDTH];
               state_d      = StAccess;
            end
         end
         StAccess: begin
            cnt_d   = CntWidth'(MEM_LATENCY - 1);
            state_d = StWait;
         end
         StWait: begin
            if (cnt_q == '0) begin
               if (!wren_q) begin
                  rddata_d = mem_rdData;
               end
               state_d = StResp;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         StResp: begin
            last_d  = win_q;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         state_q      <= StIdle;
         last_q       <= IdxWidth'(CORE_COUNT - 1);
         win_q        <= '0;
         wren_q       <= 1'b0;
         mem_addr_q   <= '0;
         mem_wrdata_q <= '0;
         rddata_q     <= '0;
         cnt_q        <= '0;
      end else begin
         state_q      <= state_d;
         last_q       <= last_d;
         win_q        <= win_d;
         wren_q       <= wren_d;
         mem_addr_q   <= mem_addr_d;
         mem_wrdata_q <= mem_wrdata_d;
         rddata_q     <= rddata_d;
         cnt_q        <= cnt_d;
      end
   end

   always_comb begin
      done = '0;
      if (state_q == StResp) begin
         done[win_q] = 1'b1;
      end
   end

   assign busy       = (state_q != StIdle);
   assign mem_rdEn   = (state_q == StAccess) && !wren_q;
   assign mem_wrEn   = (state_q == StAccess) && wren_q;
   assign mem_addr   = mem_addr_q;
   assign mem_wrData = mem_wrdata_q;
   assign rdData     = rddata_q;

`ifdef MEM_ARB_STATS_EN
   logic [StatsWidth-1:0] grant_cnt_q [CORE_COUNT];

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         for (int i = 0; i < int'(CORE_COUNT); i++) begin
            grant_cnt_q[i] <= '0;
         end
      end else if (state_q == StResp && grant_cnt_q[win_q] != '1) begin
         grant_cnt_q[win_q] <= grant_cnt_q[win_q] + 1'b1;
      end
   end

   for (genvar g = 0; g < CORE_COUNT; g++) begin : g_stats
      assign grant_cnt[g*StatsWidth +: StatsWidth] = grant_cnt_q[g];
   end
`endif

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Round-robin arbiter that shares one single-port data memory among CORE_COUNT processor cores in the multicore top.
- Sits between the per-core memory request ports and the shared data RAM.
- Sequences one transaction at a time: select, issue, wait MEM_LATENCY, respond.
- Guarantees starvation-free access, with core 0 first after reset.

Parameters:
- CORE_COUNT, 2, number of requesting cores (2..16)
- ADDR_WIDTH, 12, memory address width
- DATA_WIDTH, 12, memory data width
- MEM_LATENCY, 1, cycles from memory enable to valid mem_rdData (>=1)

Ports:
- clk  in  1  system clock, rising edge
- rstN  in  1  asynchronous active-low reset
- req  in  CORE_COUNT  per-core request; held high until matching done pulse
- wrEn  in  CORE_COUNT  per-core 1=write, 0=read; qualified by req
- addr  in  CORE_COUNT*ADDR_WIDTH  per-core address, core i at slice [i*ADDR_WIDTH +: ADDR_WIDTH]
- wrData  in  CORE_COUNT*DATA_WIDTH  per-core write data, same slicing
- done  out  CORE_COUNT  one-cycle completion pulse, one-hot
- rdData  out  DATA_WIDTH  read data broadcast to all cores; valid with done
- busy  out  1  high whenever state != IDLE
- mem_addr  out  ADDR_WIDTH  shared memory address
- mem_wrData  out  DATA_WIDTH  shared memory write data
- mem_wrEn  out  1  memory write strobe
- mem_rdEn  out  1  memory read strobe
- mem_rdData  in  DATA_WIDTH  memory read data

Behaviour:
- Reset (async, rstN=0):
  - state=IDLE.
  - done, busy, mem_wrEn, mem_rdEn = 0.
  - mem_addr, mem_wrData, rdData = 0.
  - Round-robin pointer last=CORE_COUNT-1.
  - Latency counter = 0.
- FSM states IDLE, ACCESS, WAIT, RESP:
  - IDLE: if any req bit is set, the winner is the first set bit searching last+1, last+2, ... mod CORE_COUNT. Register winner index, its addr, wrData and wrEn, then go to ACCESS. If no req, stay in IDLE.
  - ACCESS: exactly one cycle. mem_rdEn=~wrEn_l or mem_wrEn=wrEn_l is high. mem_addr and mem_wrData are driven from the registered values. Load counter with MEM_LATENCY-1, then go to WAIT.
  - WAIT: strobes are low. When counter==0, capture mem_rdData into rdData (reads only; writes leave rdData unchanged) and go to RESP. Otherwise decrement the counter.
  - RESP: done[winner]=1 for this cycle only. Set last=winner, then go to IDLE.
- Latency: req first seen in IDLE at cycle N gives strobe at N+1 and done at N+2+MEM_LATENCY. Reads and writes have identical timing.
- Back-to-back: the core that was just served may be re-selected in the IDLE cycle after RESP, but only if no other core requests. This gives a minimum 3+MEM_LATENCY cycle period per transaction.
- Simultaneous requests: the strict rotation rule above decides the winner. Ties are impossible.
- req withdrawn mid-transaction: the transaction completes and done still pulses. New req bits are ignored outside IDLE.
- mem_addr and mem_wrData hold their last driven value outside ACCESS.
- Reset mid-operation: abort immediately, all outputs go to reset values, no done is issued.
- rdData is stable from capture until the next read capture.

Optional Feature:
- Macro MEM_ARB_STATS_EN.
- Defined:
  - Extra output grant_cnt, CORE_COUNT*16 bits.
  - One counter per core, incremented in RESP for the winner, saturating at 16'hFFFF.
  - Counters clear on reset.
- Undefined: port and counters are absent. Core behaviour is identical either way.

Decomposition:
- Shared package mem_arb_pkg:
  - FSM state encoding (IDLE=2'd0, ACCESS=2'd1, WAIT=2'd2, RESP=2'd3).
  - Stats counter width constant 16.
- Sub-module rr_select:
  - Combinational rotating priority pick.
  - Inputs req and last; outputs valid and winner index ($clog2(CORE_COUNT) bits).
  - Reused by the future instruction-memory arbiter.

Test Plan:
- Reset then single read: core1 req, addr=12'h010, memory holds 12'h0AB. Expect mem_rdEn at N+1, done=2'b10 at N+3, rdData=12'h0AB.
- Write then read-back: core0 writes 12'h555 to 12'h020, then reads 12'h020. Expect mem_wrEn one cycle, then rdData=12'h555.
- Contention: both cores hold req from reset for 4 transactions. Expect grant order 0,1,0,1. Each done is one-hot and one cycle.
- Latency sweep: MEM_LATENCY=3 with CORE_COUNT=4 and all cores requesting. Expect done at N+5 and order 0,1,2,3.
- Abort: rstN low during WAIT. Expect immediate busy=0, no done. After release, core0 is served first.
- Stats (MEM_ARB_STATS_EN): 5 grants to core0 and 3 to core1. Expect grant_cnt slices equal 5 and 3.
